// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the 9-bit core sequencer: FSM state encoding,
// instruction-type codes (also used by the decoder) and the default pc width.
package instr_sequencer_pkg;

   localparam int PC_W_DEFAULT = 8;

   localparam logic [1:0] TYPE_R   = 2'b00;
   localparam logic [1:0] TYPE_I   = 2'b01;
   localparam logic [1:0] TYPE_MEM = 2'b10;
   localparam logic [1:0] TYPE_BR  = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      MEM   = 3'd3,
      HALT  = 3'd4
   } state_t;

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the 9-bit core. Owns the pc and steps each
// instruction through FETCH -> EXEC (-> MEM) -> FETCH, or into HALT.
// Strobes decode from the registered state plus decode inputs, so an
// asynchronous reset removes mem_req without waiting for a clock edge.
// Optional build macro RETIRE_COUNT_EN adds a saturating retired-instruction
// counter on output retire_count (CNT_W bits).
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int PC_W  = PC_W_DEFAULT
`ifdef RETIRE_COUNT_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        instr_type,
   input  logic              done_flag,
   input  logic              mem_load,
   input  logic              branch_eq,
   input  logic [PC_W-1:0]   jump_target,
   input  logic              mem_ack,
   output logic [PC_W-1:0]   pc,
   output logic              ir_load,
   output logic              reg_we,
   output logic              mem_req,
   output logic              mem_we,
   output logic              busy,
`ifdef RETIRE_COUNT_EN
   output logic [CNT_W-1:0]  retire_count,
`endif
   output logic              done
);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              done_q, done_d;
   logic [PC_W-1:0]   pc_inc;

   assign pc_inc = pc_q + PC_W'(1);

   // Next-state, next-pc and done decode; done_flag outranks branch_eq.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      done_d  = done_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               pc_d    = '0;
               state_d = FETCH;
            end
         end
         FETCH: state_d = EXEC;
         EXEC: begin
            case (instr_type)
               TYPE_R, TYPE_I: begin
                  pc_d    = pc_inc;
                  state_d = FETCH;
               end
               TYPE_MEM: state_d = MEM;
               default: begin
                  if (done_flag) begin
                     done_d  = 1'b1;
                     state_d = HALT;
                  end else begin
                     pc_d    = branch_eq ? jump_target : pc_inc;
                     state_d = FETCH;
                  end
               end
            endcase
         end
         MEM: begin
            if (mem_ack) begin
               pc_d    = pc_inc;
               state_d = FETCH;
            end
         end
         HALT: begin
            if (start) begin
               pc_d    = '0;
               done_d  = 1'b0;
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, pc and done registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
      end
   end

   assign pc      = pc_q;
   assign done    = done_q;
   assign ir_load = (state_q == FETCH);
   assign busy    = (state_q == FETCH) || (state_q == EXEC) || (state_q == MEM);
   assign mem_req = (state_q == MEM);
   assign mem_we  = (state_q == MEM) && !mem_load;
   // R/I write back in EXEC; a load writes back in the cycle its ack arrives.
   assign reg_we  = ((state_q == EXEC) && ((instr_type == TYPE_R) || (instr_type == TYPE_I)))
                 || ((state_q == MEM) && mem_ack && mem_load);

`ifdef RETIRE_COUNT_EN
   logic [CNT_W-1:0] retire_q, retire_d;
   logic             retire_inc;
   logic             start_acc;

   // An instruction retires when EXEC leaves for FETCH or HALT, or MEM is acked.
   assign retire_inc = ((state_q == EXEC) && (instr_type != TYPE_MEM))
                    || ((state_q == MEM) && mem_ack);
   assign start_acc  = start && ((state_q == IDLE) || (state_q == HALT));

   // Retire counter next value: clear on accepted start, saturate at all-ones.
   always_comb begin
      retire_d = retire_q;
      if (start_acc) begin
         retire_d = '0;
      end else if (retire_inc && !(&retire_q)) begin
         retire_d = retire_q + CNT_W'(1);
      end
   end

   // Retire counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_q <= '0;
      end else begin
         retire_q <= retire_d;
      end
   end

   assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer. A behavioural ROM feeds decode
// inputs from the current pc; a memory model acks after a per-instruction
// delay. Stimulus pushes hand-computed events; a negedge monitor pops them.
// Event kinds: 0 = fetch {pc, cycles since previous fetch},
//              1 = register write {pc},
//              2 = memory completion {pc, mem_we, MEM cycles, reg_we}.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  instr_type;
   logic        done_flag;
   logic        mem_load;
   logic        branch_eq;
   logic [7:0]  jump_target;
   logic        mem_ack;
   logic [7:0]  pc;
   logic        ir_load;
   logic        reg_we;
   logic        mem_req;
   logic        mem_we;
   logic        busy;
   logic        done;
`ifdef RETIRE_COUNT_EN
   logic [15:0] retire_count;
`endif

   always #5 clk = ~clk;

   instr_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .instr_type  (instr_type),
      .done_flag   (done_flag),
      .mem_load    (mem_load),
      .branch_eq   (branch_eq),
      .jump_target (jump_target),
      .mem_ack     (mem_ack),
      .pc          (pc),
      .ir_load     (ir_load),
      .reg_we      (reg_we),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .busy        (busy),
`ifdef RETIRE_COUNT_EN
      .retire_count(retire_count),
`endif
      .done        (done)
   );

   typedef struct {
      logic [1:0] typ;
      logic       dn;
      logic       ld;
      logic       eq;
      logic [7:0] tgt;
      int         dly;
   } rom_t;

   typedef struct {
      int kind;
      int pc;
      int a;
      int b;
      int c;
   } ev_t;

   rom_t rom [256];
   ev_t  exp_q [$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   mem_cnt;

   // ROM contents as seen through the instruction register.
   always_comb begin
      instr_type  = rom[pc].typ;
      done_flag   = rom[pc].dn;
      mem_load    = rom[pc].ld;
      branch_eq   = rom[pc].eq;
      jump_target = rom[pc].tgt;
      mem_ack     = mem_req && (mem_cnt == rom[pc].dly);
   end

   // Counts completed MEM cycles of the current request.
   always @(posedge clk or posedge reset) begin
      if (reset || !mem_req || mem_ack) mem_cnt <= 0;
      else                              mem_cnt <= mem_cnt + 1;
   end

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic push(input int k, input int p, input int a, input int b, input int c);
      ev_t e;
      e.kind = k; e.pc = p; e.a = a; e.b = b; e.c = c;
      exp_q.push_back(e);
   endtask

   task automatic put(input int a, input logic [1:0] t, input logic dn, input logic ld,
                      input logic eq, input logic [7:0] tgt, input int dly);
      rom[a].typ = t; rom[a].dn = dn; rom[a].ld = ld;
      rom[a].eq = eq; rom[a].tgt = tgt; rom[a].dly = dly;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) put(i, 2'b11, 1'b1, 1'b0, 1'b0, 8'h00, 0);
   endtask

   // Monitor: decoupled from stimulus, compares each observed event.
   int   mon_gap = 0;
   int   mon_mcnt = 0;
   logic mon_mwe = 1'b0;

   task automatic compare_ev(input ev_t got);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got kind=%0d pc=%0d a=%0d b=%0d c=%0d expected none",
                  got.kind, got.pc, got.a, got.b, got.c);
      end else begin
         e = exp_q.pop_front();
         if (e != got) begin
            n_err++;
            $display("FAIL event: got kind=%0d pc=%0d a=%0d b=%0d c=%0d expected kind=%0d pc=%0d a=%0d b=%0d c=%0d",
                     got.kind, got.pc, got.a, got.b, got.c, e.kind, e.pc, e.a, e.b, e.c);
         end else begin
            $display("ev   kind=%0d pc=%0d a=%0d b=%0d c=%0d", got.kind, got.pc, got.a, got.b, got.c);
         end
      end
   endtask

   always @(negedge clk) begin
      ev_t got;
      if (reset) begin
         mon_gap  = 0;
         mon_mcnt = 0;
      end else begin
         if (busy) mon_gap++;
         else      mon_gap = 0;
         if (ir_load && (reg_we || mem_req)) chk("strobe_exclusive", 1, 0);
         if (ir_load) begin
            got.kind = 0; got.pc = int'(pc); got.a = mon_gap; got.b = 0; got.c = 0;
            mon_gap = 0;
            compare_ev(got);
         end else if (mem_req) begin
            mon_mcnt++;
            if (mon_mcnt == 1) mon_mwe = mem_we;
            else               chk("mem_we_stable", int'(mem_we), int'(mon_mwe));
            if (mem_ack) begin
               got.kind = 2; got.pc = int'(pc); got.a = int'(mem_we);
               got.b = mon_mcnt; got.c = int'(reg_we);
               mon_mcnt = 0;
               compare_ev(got);
            end
         end else begin
            mon_mcnt = 0;
            if (reg_we) begin
               got.kind = 1; got.pc = int'(pc); got.a = 0; got.b = 0; got.c = 0;
               compare_ev(got);
            end
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (n < max) begin
         @(posedge clk); #1;
         n++;
         if (done) break;
      end
   endtask

   task automatic wait_q_empty(input string name, input int max);
      int n = 0;
      while (exp_q.size() != 0 && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      int n;
      clear_rom();
      reset = 1'b1;
      start = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", int'(pc), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_strobes", int'({ir_load, reg_we, mem_req, mem_we}), 0);
      @(posedge clk); #1 reset = 1'b0;

      // Program 1: R, I, Branch(done).
      put(0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      put(1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      put(2, 2'b11, 1'b1, 1'b0, 1'b0, 8'h00, 0);
      push(0, 0, 1, 0, 0); push(1, 0, 0, 0, 0);
      push(0, 1, 2, 0, 0); push(1, 1, 0, 0, 0);
      push(0, 2, 2, 0, 0);
      pulse_start();
      wait_done(50, n);
      chk("p1_cycles_to_done", n, 6);
      chk("p1_done", int'(done), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("p1_pc_frozen", int'(pc), 2);
      chk("p1_busy", int'(busy), 0);
`ifdef RETIRE_COUNT_EN
      chk("p1_retire", int'(retire_count), 3);
`endif
      wait_q_empty("p1_queue", 5);

      // Program 2: branch fallthrough, store (3 MEM cycles), load (ack first
      // cycle), taken branch to 0x10, fallthrough, halt at 0x11.
      clear_rom();
      put(0,  2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      put(1,  2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      put(2,  2'b11, 1'b0, 1'b0, 1'b0, 8'h40, 0);
      put(3,  2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 2);
      put(4,  2'b10, 1'b0, 1'b1, 1'b0, 8'h00, 0);
      put(5,  2'b11, 1'b0, 1'b0, 1'b1, 8'h10, 0);
      put(16, 2'b11, 1'b0, 1'b0, 1'b0, 8'h30, 0);
      put(17, 2'b11, 1'b1, 1'b0, 1'b1, 8'h50, 0);
      push(0, 0, 1, 0, 0); push(1, 0, 0, 0, 0);
      push(0, 1, 2, 0, 0); push(1, 1, 0, 0, 0);
      push(0, 2, 2, 0, 0);
      push(0, 3, 2, 0, 0); push(2, 3, 1, 3, 0);
      push(0, 4, 5, 0, 0); push(2, 4, 0, 1, 1);
      push(0, 5, 3, 0, 0);
      push(0, 16, 2, 0, 0);
      push(0, 17, 2, 0, 0);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("p2_restart_done", int'(done), 0);
      chk("p2_restart_pc", int'(pc), 0);
      chk("p2_restart_busy", int'(busy), 1);
`ifdef RETIRE_COUNT_EN
      chk("p2_restart_retire", int'(retire_count), 0);
`endif
      // start while busy must be ignored
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(100, n);
      chk("p2_done", int'(done), 1);
      chk("p2_pc", int'(pc), 17);
`ifdef RETIRE_COUNT_EN
      chk("p2_retire", int'(retire_count), 8);
`endif
      wait_q_empty("p2_queue", 5);

      // Program 3: jump to 0xFF, I-type there wraps pc to 0.
      clear_rom();
      put(0,   2'b11, 1'b0, 1'b0, 1'b1, 8'hFF, 0);
      put(255, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      push(0, 0, 1, 0, 0);
      push(0, 255, 2, 0, 0); push(1, 255, 0, 0, 0);
      push(0, 0, 2, 0, 0);
      pulse_start();
      wait_q_empty("p3_queue", 40);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("p3_idle_pc", int'(pc), 0);
      chk("p3_idle_busy", int'(busy), 0);

      // Program 4: store that never acks; reset mid-MEM drops mem_req at once.
      clear_rom();
      put(0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 100);
      push(0, 0, 1, 0, 0);
      pulse_start();
      n = 0;
      while (!mem_req && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("p4_mem_req_seen", int'(mem_req), 1);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("p4_async_mem_req", int'(mem_req), 0);
      chk("p4_async_busy", int'(busy), 0);
      chk("p4_async_pc", int'(pc), 0);
      chk("p4_async_reg_we", int'(reg_we), 0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("p4_after_busy", int'(busy), 0);
      chk("p4_queue", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
